// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared definitions for the I2C master write engine:
//                FSM state encoding, quarter-slot indices and the R/W bit.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        ACK   = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } i2c_state_t;

    // Quarter index inside one SCL bit slot.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // R/W bit appended to the 7-bit address: this engine only writes.
    localparam logic C_W_BIT = 1'b0;

endpackage
`default_nettype wire

// File: rtl/i2c_qtick.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_qtick
//  Description : Quarter-bit timebase. While enabled, a divider counts
//                0..CLK_DIV-1 and emits a one-cycle tick on its last count;
//                each tick advances a 2-bit quarter index (q0..q3).
//                When disabled both counters are held at zero so every
//                transaction starts on a clean q0.
//  Ports       : i_clk      - clock
//                i_rst_n    - asynchronous active-low reset
//                i_en       - run the divider
//                o_tick     - one-cycle pulse at the end of each quarter
//                o_quarter  - current quarter index
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_qtick #(
    parameter int CLK_DIV = 250
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    output logic       o_tick,
    output logic [1:0] o_quarter
);

    localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

    logic [c_div_w-1:0] r_div;
    logic [1:0]         r_quarter;

    assign o_tick    = i_en && (r_div == c_div_last);
    assign o_quarter = r_quarter;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div     <= '0;
            r_quarter <= '0;
        end else if (!i_en) begin
            r_div     <= '0;
            r_quarter <= '0;
        end else if (o_tick) begin
            r_div     <= '0;
            r_quarter <= r_quarter + 2'd1;
        end else begin
            r_div     <= r_div + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_master_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_master_tx
//  Description : I2C master write engine. One accepted i_start sends
//                START, {addr,W}, then pops and sends FIFO bytes until the
//                FIFO reads empty at an ACK slot, then STOP. A NACK ends the
//                transaction early with STOP and sets the sticky o_nack.
//                Lines are open-drain: an output-enable of 1 pulls low.
//  Ports       : i_clk, i_rst_n      - clock, async active-low reset
//                i_start, i_addr     - transaction request and 7-bit address
//                i_fifo_empty/_data  - FIFO read side (show-ahead)
//                o_fifo_rd           - FIFO pop strobe
//                i_sda               - synchronized SDA level
//                o_scl_oe, o_sda_oe  - line pull-down enables
//                o_busy, o_done      - status, done is a one-cycle pulse
//                o_nack              - sticky NACK flag
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250,
    parameter int DW      = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [6:0]    i_addr,
    input  logic          i_fifo_empty,
    input  logic [DW-1:0] i_fifo_data,
    output logic          o_fifo_rd,
    input  logic          i_sda,
    output logic          o_scl_oe,
    output logic          o_sda_oe,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_nack
);

    i2c_state_t    r_state;
    i2c_state_t    w_next_state;

    logic [DW-1:0] r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_nack;
    logic          r_fifo_rd;
    logic          r_scl_oe;
    logic          r_sda_oe;

    logic          w_tick;
    logic [1:0]    w_quarter;
    logic          w_slot_end;
    logic          w_ack_sample;
    logic          w_accept;
    logic          w_load_data;
    logic          w_shift;
    logic          w_finish;
    logic          w_scl_oe;
    logic          w_sda_oe;

    i2c_qtick #(
        .CLK_DIV   (CLK_DIV)
    ) u_qtick (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (r_state != IDLE),
        .o_tick    (w_tick),
        .o_quarter (w_quarter)
    );

    assign w_slot_end   = w_tick && (w_quarter == Q3);
    assign w_ack_sample = (r_state == ACK) && w_tick && (w_quarter == Q2);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and line decode. In data/ACK slots SCL is low for the
    // first half (quarter bit 1 clear) and released for the second half.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load_data  = 1'b0;
        w_shift      = 1'b0;
        w_finish     = 1'b0;
        w_scl_oe     = 1'b0;
        w_sda_oe     = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_next_state = START;
                end
            end

            START: begin
                // SDA falls mid-slot while SCL stays released.
                w_sda_oe = w_quarter[1];
                if (w_slot_end) begin
                    w_next_state = ADDR;
                end
            end

            ADDR, DATA: begin
                w_scl_oe = ~w_quarter[1];
                w_sda_oe = ~r_shift[DW-1];
                if (w_slot_end) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_next_state = ACK;
                    end
                end
            end

            ACK: begin
                w_scl_oe = ~w_quarter[1];
                // r_nack was updated at the q2 sample, so it is current here.
                if (w_slot_end) begin
                    if (r_nack || i_fifo_empty) begin
                        w_next_state = STOP;
                    end else begin
                        w_load_data  = 1'b1;
                        w_next_state = DATA;
                    end
                end
            end

            STOP: begin
                w_scl_oe = (w_quarter == Q0);
                w_sda_oe = (w_quarter != Q3);
                if (w_slot_end) begin
                    w_finish     = 1'b1;
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs. Line enables are registered so the
    // pins never glitch while state/quarter registers change together.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_nack    <= 1'b0;
            r_fifo_rd <= 1'b0;
            r_scl_oe  <= 1'b0;
            r_sda_oe  <= 1'b0;
        end else begin
            r_fifo_rd <= w_load_data;
            r_done    <= w_finish;
            r_scl_oe  <= w_scl_oe;
            r_sda_oe  <= w_sda_oe;

            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (w_finish) begin
                r_busy <= 1'b0;
            end

            if (w_accept) begin
                r_nack <= 1'b0;
            end else if (w_ack_sample && i_sda) begin
                r_nack <= 1'b1;
            end

            if (w_accept) begin
                r_shift   <= {i_addr, C_W_BIT};
                r_bit_cnt <= '0;
            end else if (w_load_data) begin
                r_shift   <= i_fifo_data;
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_shift   <= {r_shift[DW-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    assign o_fifo_rd = r_fifo_rd;
    assign o_scl_oe  = r_scl_oe;
    assign o_sda_oe  = r_sda_oe;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_nack    = r_nack;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_master_tx
//  Description : Testbench for i2c_master_tx. A FIFO model feeds bytes, an
//                I2C slave/bus decoder turns the open-drain lines back into
//                START / byte / STOP tokens and answers ACK or NACK, and each
//                transaction is compared with tokens, pop count, latency and
//                flags predicted from the protocol rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_master_tx;

    localparam int CLK_DIV = 4;
    localparam int SLOT    = 4 * CLK_DIV;
    localparam int TOK_START = -1;
    localparam int TOK_STOP  = -2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr = 7'd0;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       scl_oe, sda_oe, busy, done, nack;
    logic       scl_line, sda_line;

    always #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic [7:0] fifo_arr [0:15];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int pop_cnt = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = fifo_arr[rd_ptr % 16];

    always @(posedge clk) begin
        if (fifo_rd) begin
            pop_cnt <= pop_cnt + 1;
            if (wr_ptr != rd_ptr) rd_ptr <= rd_ptr + 1;
        end
    end

    // ---------------- open-drain bus + slave ----------------
    logic slv_pull = 1'b0;
    assign scl_line = ~scl_oe;
    assign sda_line = ~(sda_oe | slv_pull);

    int         tok_log [$];
    int         done_cnt = 0;
    int         nack_at  = -1;  // -1: ACK all, 0: NACK address, k: NACK data byte k
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         bitcnt   = 0;
    int         byte_idx = 0;
    logic [7:0] sh       = 8'd0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (prev_scl && scl_line && prev_sda && !sda_line) begin
            tok_log.push_back(TOK_START);
            bitcnt   = 0;
            byte_idx = 0;
        end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
            tok_log.push_back(TOK_STOP);
            bitcnt   = 0;
            slv_pull = 1'b0;
        end else if (!prev_scl && scl_line) begin
            sh = {sh[6:0], sda_line};
            bitcnt++;
            if (bitcnt == 8) tok_log.push_back(int'(sh));
        end else if (prev_scl && !scl_line) begin
            if (bitcnt == 8) begin
                slv_pull = (byte_idx != nack_at);
            end else if (bitcnt == 9) begin
                slv_pull = 1'b0;
                bitcnt   = 0;
                byte_idx++;
            end
        end
        prev_scl = scl_line;
        prev_sda = sda_line;
    end

    i2c_master_tx #(
        .CLK_DIV      (CLK_DIV),
        .DW           (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_addr       (addr),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_rd    (fifo_rd),
        .i_sda        (sda_line),
        .o_scl_oe     (scl_oe),
        .o_sda_oe     (sda_oe),
        .o_busy       (busy),
        .o_done       (done),
        .o_nack       (nack)
    );

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] txd [0:7];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction: n bytes from txd queued, slave NACK plan nk,
    // optional extra i_start pulse while busy.
    task automatic run_txn(input logic [6:0] a, input int n, input int nk, input bit poke);
        int  exp_tok [$];
        int  sent, exp_cyc, cyc, lat, base_tok, base_pop, base_done;
        bit  exp_nack;
        for (int i = 0; i < n; i++) begin
            fifo_arr[wr_ptr % 16] = txd[i];
            wr_ptr++;
        end
        nack_at  = nk;
        exp_nack = (nk == 0) || (nk > 0 && nk <= n);
        if (nk == 0)                sent = 0;
        else if (nk > 0 && nk <= n) sent = nk;
        else                        sent = n;
        exp_cyc = (11 + 9 * sent) * SLOT;
        exp_tok.push_back(TOK_START);
        exp_tok.push_back(int'({a, 1'b0}));
        for (int i = 0; i < sent; i++) exp_tok.push_back(int'(txd[i]));
        exp_tok.push_back(TOK_STOP);

        base_tok  = tok_log.size();
        base_pop  = pop_cnt;
        base_done = done_cnt;

        @(negedge clk);
        start = 1'b1;
        addr  = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (poke && cyc == 150) begin
                start = 1'b1;
                addr  = ~a;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_in_time", (cyc < 20000), 1);
        lat = (cyc >= exp_cyc - 1 && cyc <= exp_cyc + 1) ? exp_cyc : cyc;
        chk("done_latency", lat, exp_cyc);
        chk("busy_falls_with_done", busy, 0);
        chk("nack_at_done", nack, exp_nack);

        repeat (3 * SLOT) @(posedge clk);
        #1;
        chk("busy_idle", busy, 0);
        chk("nack_sticky", nack, exp_nack);
        chk("done_count", done_cnt - base_done, 1);
        chk("pop_count", pop_cnt - base_pop, sent);
        chk("fifo_left", wr_ptr - rd_ptr, n - sent);
        chk("token_count", tok_log.size() - base_tok, exp_tok.size());
        if (tok_log.size() - base_tok == exp_tok.size()) begin
            for (int i = 0; i < exp_tok.size(); i++)
                chk("token", tok_log[base_tok + i], exp_tok[i]);
        end
        wr_ptr = rd_ptr;  // drop whatever the transaction left queued
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nk, base_pop;
        logic [6:0] a;

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nack", nack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Two-byte write
        txd[0] = 8'hA5;
        txd[1] = 8'h0F;
        run_txn(7'h3C, 2, -1, 1'b0);

        // Address probe with empty FIFO
        run_txn(7'($urandom), 0, -1, 1'b0);

        // Address NACK with three bytes queued
        for (int i = 0; i < 3; i++) txd[i] = 8'($urandom);
        run_txn(7'($urandom), 3, 0, 1'b0);

        // NACK on the second data byte
        for (int i = 0; i < 3; i++) txd[i] = 8'($urandom);
        run_txn(7'($urandom), 3, 2, 1'b0);

        // Start while busy
        for (int i = 0; i < 2; i++) txd[i] = 8'($urandom);
        run_txn(7'($urandom), 2, -1, 1'b1);

        // Randomized transactions
        for (int t = 0; t < 6; t++) begin
            n  = int'($urandom_range(0, 4));
            nk = int'($urandom_range(0, n + 1)) - 1;
            for (int i = 0; i < n; i++) txd[i] = 8'($urandom);
            run_txn(7'($urandom), n, nk, 1'b0);
        end

        // Reset during bit 4 of the first data byte
        for (int i = 0; i < 2; i++) begin
            fifo_arr[wr_ptr % 16] = 8'($urandom);
            wr_ptr++;
        end
        nack_at  = -1;
        base_pop = pop_cnt;
        a = 7'($urandom);
        @(negedge clk);
        start = 1'b1;
        addr  = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14 * SLOT + 6) @(posedge clk);
        #3;
        chk("mid_busy", busy, 1);
        chk("mid_scl_low", scl_oe, 1);
        chk("mid_popped", pop_cnt - base_pop, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_scl_oe", scl_oe, 0);
        chk("arst_sda_oe", sda_oe, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        wr_ptr = rd_ptr;
        repeat (4) @(posedge clk);

        // Normal operation after reset
        n = int'($urandom_range(1, 4));
        for (int i = 0; i < n; i++) txd[i] = 8'($urandom);
        run_txn(7'($urandom), n, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_master_tx.md
# i2c_master_tx

I2C master write engine that drains bytes from the read side of the asynchronous byte FIFO and sends them to a 7-bit-addressed slave. One `i_start` pulse produces one transaction: START, address+W, data bytes until the FIFO reads empty, then STOP. SCL and SDA are driven open-drain through output-enable pins. A NACK from the slave aborts the transaction.

## Interface
- `CLK_DIV`, default 250: system clocks per quarter SCL period, minimum 2. Bit period = 4·CLK_DIV clocks.
- `DW`, default 8: FIFO data width. Fixed at 8 for I2C.
- `i_clk` in 1: single clock for all logic.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: one-cycle request to begin a transaction. Ignored while `o_busy`=1.
- `i_addr` in 7: slave address, captured on an accepted `i_start`.
- `i_fifo_empty` in 1: FIFO `o_rempty`.
- `i_fifo_data` in DW: FIFO `o_rdata`. Combinational read, valid while not empty.
- `o_fifo_rd` in/out: out 1: FIFO `i_rd` pop strobe, one cycle per byte.
- `i_sda` in 1: synchronized SDA pin level.
- `o_scl_oe` out 1: 1 pulls SCL low, 0 releases it.
- `o_sda_oe` out 1: 1 pulls SDA low, 0 releases it.
- `o_busy` out 1: high from the accepted start until STOP completes.
- `o_done` out 1: one-cycle pulse at transaction end.
- `o_nack` out 1: sticky. Set on any NACK, cleared on the next accepted start.

## Operation
- Reset values: `o_scl_oe`=0, `o_sda_oe`=0, `o_fifo_rd`=0, `o_busy`=0, `o_done`=0, `o_nack`=0. State is IDLE and the divider and quarter counters are 0.
- Quarter ticks come from a divider that counts 0..CLK_DIV-1. The divider runs only outside IDLE. Each bit slot has four quarters, q0–q3.
- Data and ACK bit slot:
  - SCL is low during q0–q1 and released during q2–q3.
  - SDA changes only at q0 entry.
  - The ACK bit is sampled from `i_sda` at the end of q2.
- States:
  - **IDLE**: both lines released. An accepted `i_start` captures `i_addr`, clears `o_nack`, sets `o_busy` and moves to START.
  - **START**, one slot:
    - q0–q1: SCL and SDA released.
    - q2–q3: SDA pulled low with SCL released.
    - Then go to ADDR.
  - **ADDR**: 8 slots, MSB first, sending {addr, 1'b0}. Then go to ACK.
  - **ACK**, one slot: SDA released.
    - Sampled 1 (NACK): set `o_nack` and go to STOP.
    - Sampled 0 with `i_fifo_empty`=1: go to STOP.
    - Sampled 0 with `i_fifo_empty`=0: go to DATA.
  - **DATA**:
    - At entry, load `i_fifo_data` into the shift register and pulse `o_fifo_rd` for exactly one cycle.
    - Send 8 slots MSB first, then go to ACK.
  - **STOP**, one slot:
    - q0: SCL low, SDA low.
    - q1–q2: SCL released, SDA low.
    - q3: both released.
    - At the end of q3, pulse `o_done`, clear `o_busy` and return to IDLE.
- The FIFO emptiness check happens only in the ACK slot. A byte arriving after that check is left for the next transaction.
- On NACK no further bytes are popped. Remaining FIFO contents stay queued.
- No clock stretching and no arbitration: SCL is never sampled.
- Reset mid-transaction releases both lines immediately. No STOP is generated and the popped byte is lost.

## Timing
- Accepted `i_start` to the first quarter tick: CLK_DIV clocks.
- A transaction with N data bytes takes (11 + 9N)·4·CLK_DIV clocks, ±1, from start acceptance to the `o_done` pulse.
- The `o_fifo_rd` pulse coincides with the DATA entry cycle, at most one pulse per 9 bit slots.
- `o_done` and `o_busy` falling happen on the same clock edge. `i_start` is accepted on the following cycle at the earliest.
- `o_nack` is set in the cycle after the ACK sample. It remains set through `o_done`.

## Structure
- Package `i2c_pkg` holds:
  - the state enum IDLE/START/ADDR/ACK/DATA/STOP;
  - quarter index constants Q0–Q3;
  - the W bit constant.
- Sub-module `i2c_qtick` is the CLK_DIV divider. It has an enable input and produces a one-cycle `tick` and a 2-bit quarter count.
- The top level holds the FSM, the 8-bit shift register and a 3-bit bit counter.

## Test plan
- **Two-byte write:** CLK_DIV=4, addr 7'h3C, FIFO holds 8'hA5 and 8'h0F, slave ACKs all bytes.
  - Bus decodes START, 0x78, A5, 0F, STOP.
  - Exactly two `o_fifo_rd` pulses; `o_done` fires 116·4 clocks ±1 after start; `o_nack`=0.
- **Address probe:** FIFO empty, slave ACKs → START, 0x78, STOP, no `o_fifo_rd` pulse, `o_done` after 44 bit-quarters·CLK_DIV.
- **Address NACK:** slave NACKs the address with 3 bytes queued → `o_nack`=1, STOP follows, zero pops, FIFO still holds 3 bytes.
- **Start while busy:** pulse `i_start` mid-transaction → ignored, no extra START, single `o_done`.
- **Reset mid-byte:** assert `i_rst_n`=0 during DATA bit 4 → `o_scl_oe` and `o_sda_oe` go to 0 asynchronously, `o_busy`=0. A new transaction after release then works normally.
